// File: rtl/sa_feed_ctrl.sv
// Operand sequencer for one systolic array: latches A/B, clears the array, streams
// diagonally skewed vectors, then captures C under a valid/ready handshake with a watchdog.
module sa_feed_ctrl #(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 10,
  parameter int TIMEOUT    = 64
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0]      a_mat,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0]      b_mat,
  output logic                                           busy,
  output logic                                           sa_clear,
  output logic [SIZE-1:0][DATA_WIDTH-1:0]                sa_a,
  output logic [SIZE-1:0][DATA_WIDTH-1:0]                sa_b,
  input  logic                                           sa_done,
  input  logic [SIZE-1:0][SIZE-1:0][2*DATA_WIDTH-1:0]    sa_c,
  output logic [SIZE-1:0][SIZE-1:0][2*DATA_WIDTH-1:0]    res_c,
  output logic                                           res_valid,
  input  logic                                           res_ready,
  output logic                                           err_timeout
);

  localparam int TW = $clog2(2*SIZE+1);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [TW-1:0] T_LAST  = TW'(2*SIZE);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT-1);

  typedef logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] mat_t;
  typedef logic [SIZE-1:0][DATA_WIDTH-1:0]           vec_t;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_WAIT, S_HOLD} state_t;

  state_t                                         r_state;
  mat_t                                           r_a;
  mat_t                                           r_b;
  logic [TW-1:0]                                  r_t;
  logic [WW-1:0]                                  r_wd;
  logic                                           r_sa_clear;
  vec_t                                           r_sa_a;
  vec_t                                           r_sa_b;
  logic [SIZE-1:0][SIZE-1:0][2*DATA_WIDTH-1:0]    r_res_c;
  logic                                           r_res_valid;
  logic                                           r_err;

  // Row i of A enters the array delayed by i cycles: lane i carries A[i][t-i].
  function automatic vec_t skew_a(input mat_t m, input logic [TW-1:0] t);
    vec_t v;
    int   d;
    v = '0;
    for (int i = 0; i < SIZE; i++) begin
      d = int'(t) - i;
      if (d >= 0 && d < SIZE) v[i] = m[i][IW'(d)];
      else                    v[i] = '0;
    end
    return v;
  endfunction

  // Column j of B enters delayed by j cycles: lane j carries B[t-j][j].
  function automatic vec_t skew_b(input mat_t m, input logic [TW-1:0] t);
    vec_t v;
    int   d;
    v = '0;
    for (int j = 0; j < SIZE; j++) begin
      d = int'(t) - j;
      if (d >= 0 && d < SIZE) v[j] = m[IW'(d)][j];
      else                    v[j] = '0;
    end
    return v;
  endfunction

  // Sequencer state, feed counter, watchdog and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_t         <= '0;
      r_wd        <= '0;
      r_sa_clear  <= 1'b0;
      r_sa_a      <= '0;
      r_sa_b      <= '0;
      r_res_c     <= '0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sa_clear <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a        <= a_mat;
            r_b        <= b_mat;
            r_err      <= 1'b0;
            r_sa_clear <= 1'b1;
            r_state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_t     <= '0;
          r_sa_a  <= skew_a(r_a, '0);
          r_sa_b  <= skew_b(r_b, '0);
          r_state <= S_FEED;
        end
        S_FEED: begin
          if (r_t == T_LAST) begin
            r_sa_a  <= '0;
            r_sa_b  <= '0;
            r_wd    <= '0;
            r_state <= S_WAIT;
          end else begin
            r_t    <= r_t + TW'(1);
            r_sa_a <= skew_a(r_a, r_t + TW'(1));
            r_sa_b <= skew_b(r_b, r_t + TW'(1));
          end
        end
        S_WAIT: begin
          // done on the final watchdog cycle still wins over the timeout
          if (sa_done) begin
            r_res_c     <= sa_c;
            r_res_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else if (r_wd == WD_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wd <= r_wd + WW'(1);
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign sa_clear    = r_sa_clear;
  assign sa_a        = r_sa_a;
  assign sa_b        = r_sa_b;
  assign res_c       = r_res_c;
  assign res_valid   = r_res_valid;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_sa_feed_ctrl.sv
// Scoreboard bench for sa_feed_ctrl with a behavioural output-stationary systolic array
// driven by the skewed vectors; expected products come from a direct matrix multiply.
module tb_sa_feed_ctrl;

  localparam int S  = 4;
  localparam int DW = 10;
  localparam int TO = 64;
  localparam int RW = 2*DW;

  typedef logic [S-1:0][S-1:0][DW-1:0] mat_t;
  typedef logic [S-1:0][S-1:0][RW-1:0] res_t;
  typedef logic [S-1:0][DW-1:0]        vec_t;

  logic clk = 1'b0;
  logic rst, start, busy, sa_clear, sa_done, res_valid, res_ready, err_timeout;
  mat_t a_mat, b_mat;
  vec_t sa_a, sa_b;
  res_t sa_c, res_c;

  int   n_pass = 0;
  int   n_total = 0;
  int   n_res = 0;
  int   n_clr = 0;
  int   n_vld = 0;
  res_t exp_q[$];

  // behavioural array model
  logic              m_en;
  int                m_done_at;
  int                m_cnt = 0;
  logic signed [DW-1:0] m_a [S][S];
  logic signed [DW-1:0] m_b [S][S];
  logic signed [RW-1:0] m_acc [S][S];

  sa_feed_ctrl #(.SIZE(S), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .a_mat(a_mat), .b_mat(b_mat),
    .busy(busy), .sa_clear(sa_clear), .sa_a(sa_a), .sa_b(sa_b),
    .sa_done(sa_done), .sa_c(sa_c), .res_c(res_c), .res_valid(res_valid),
    .res_ready(res_ready), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  function automatic res_t mmul(input mat_t a, input mat_t b);
    res_t r;
    int   acc;
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        acc = 0;
        for (int k = 0; k < S; k++) acc += $signed(a[i][k]) * $signed(b[k][j]);
        r[i][j] = RW'(acc);
      end
    return r;
  endfunction

  // PE(i,j) multiplies the A value travelling right with the B value travelling down.
  always @(posedge clk) begin
    if (sa_clear) begin
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++) begin
          m_a[i][j]   <= '0;
          m_b[i][j]   <= '0;
          m_acc[i][j] <= '0;
        end
      m_cnt <= 0;
    end else begin
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++) begin
          m_a[i][j] <= (j == 0) ? $signed(sa_a[i]) : m_a[i][(j == 0) ? 0 : j-1];
          m_b[i][j] <= (i == 0) ? $signed(sa_b[j]) : m_b[(i == 0) ? 0 : i-1][j];
          m_acc[i][j] <= m_acc[i][j]
            + RW'((j == 0) ? $signed(sa_a[i]) : m_a[i][(j == 0) ? 0 : j-1])
            * RW'((i == 0) ? $signed(sa_b[j]) : m_b[(i == 0) ? 0 : i-1][j]);
        end
      m_cnt <= m_cnt + 1;
    end
  end

  always_comb begin
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) sa_c[i][j] = m_acc[i][j];
  end

  assign sa_done = m_en && (m_cnt >= m_done_at);

  // result monitor: a handshake happens on the next rising edge
  always @(negedge clk) begin
    #1;
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) check_eq("unexpected_result", 1, 0);
      else check_eq("res_c", res_c, exp_q.pop_front());
      n_res++;
    end
  end

  always @(negedge clk) begin
    if (sa_clear) n_clr++;
    if (res_valid) n_vld++;
  end

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) check_eq(tag, 0, 1);
  endtask

  task automatic run_one(input mat_t a, input mat_t b);
    a_mat = a;
    b_mat = b;
    start = 1'b1;
    exp_q.push_back(mmul(a, b));
    @(negedge clk);
    start = 1'b0;
    wait_valid("done_timeout", 100);
    @(negedge clk);
  endtask

  mat_t ra, id, bl, rr;
  vec_t ea, eb;
  res_t hold_exp;
  int   ref_v [4][4] = '{'{1, 2, 3, 4}, '{9, 10, 11, 12}, '{13, 14, 15, 16}, '{17, 18, 19, 20}};
  int   clr0, res0, vld0, n;

  initial begin
    rst = 1'b1; start = 1'b0; a_mat = '0; b_mat = '0; res_ready = 1'b1;
    m_en = 1'b1; m_done_at = 12;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) begin
        ra[r][c] = DW'(ref_v[r][c]);
        id[r][c] = (r == c) ? DW'(1) : DW'(0);
        bl[r][c] = DW'(r*37 - c*53 + 11);
        rr[r][c] = DW'(int'($urandom_range(200)) - 100);
      end
    bl[0][0] = DW'(-512);
    bl[3][3] = DW'(511);
    bl[1][2] = DW'(-512);
    bl[2][1] = DW'(511);

    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_clear", sa_clear, 0);
    check_eq("rst_sa_a", sa_a, 0);
    check_eq("rst_sa_b", sa_b, 0);
    check_eq("rst_res_c", res_c, 0);
    check_eq("rst_valid", res_valid, 0);
    check_eq("rst_err", err_timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    // reference multiply with skew spot checks
    a_mat = ra; b_mat = ra; start = 1'b1;
    exp_q.push_back(mmul(ra, ra));
    @(negedge clk);
    start = 1'b0;
    check_eq("clear_pulse", sa_clear, 1);
    check_eq("clear_busy", busy, 1);
    check_eq("clear_sa_a", sa_a, 0);
    repeat (4) @(negedge clk);
    ea[0] = DW'(4);  ea[1] = DW'(11); ea[2] = DW'(14); ea[3] = DW'(17);
    eb[0] = DW'(17); eb[1] = DW'(14); eb[2] = DW'(11); eb[3] = DW'(4);
    check_eq("t3_sa_a", sa_a, ea);
    check_eq("t3_sa_b", sa_b, eb);
    check_eq("t3_clear", sa_clear, 0);
    repeat (4) @(negedge clk);
    check_eq("flush_sa_a", sa_a, 0);
    check_eq("flush_sa_b", sa_b, 0);
    wait_valid("ref_timeout", 60);
    check_eq("res_c00", res_c[0][0], 126);
    @(negedge clk);
    check_eq("valid_pulse", res_valid, 0);
    check_eq("idle_after", busy, 0);

    // identity x B with signed limits, then a random product
    run_one(id, bl);
    run_one(rr, bl);

    // backpressure
    res_ready = 1'b0;
    hold_exp = mmul(bl, ra);
    a_mat = bl; b_mat = ra; start = 1'b1;
    exp_q.push_back(hold_exp);
    @(negedge clk);
    start = 1'b0;
    wait_valid("bp_timeout", 60);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        a_mat = id; b_mat = id; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check_eq("bp_valid", res_valid, 1);
      check_eq("bp_res_c", res_c, hold_exp);
      check_eq("bp_clear", sa_clear, 0);
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_busy", busy, 0);
    check_eq("bp_release_valid", res_valid, 0);
    @(negedge clk);
    check_eq("bp_no_queued_start", busy, 0);

    // watchdog expiry
    m_en = 1'b0;
    vld0 = n_vld;
    a_mat = ra; b_mat = ra; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10 + TO - 1) @(negedge clk);
    check_eq("wd_not_yet", err_timeout, 0);
    check_eq("wd_busy_before", busy, 1);
    @(negedge clk);
    check_eq("wd_err", err_timeout, 1);
    check_eq("wd_busy_after", busy, 0);
    check_eq("wd_no_valid", n_vld - vld0, 0);
    m_en = 1'b1;
    a_mat = id; b_mat = ra; start = 1'b1;
    exp_q.push_back(mmul(id, ra));
    @(negedge clk);
    start = 1'b0;
    check_eq("wd_err_cleared", err_timeout, 0);
    wait_valid("wd_retry_timeout", 60);
    @(negedge clk);

    // done on the last watchdog cycle wins
    m_done_at = 9 + TO - 1;
    run_one(ra, id);
    check_eq("wd_edge_err", err_timeout, 0);
    m_done_at = 12;

    // reset abort at FEED t=3
    vld0 = n_vld;
    res0 = n_res;
    a_mat = ra; b_mat = ra; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_clear", sa_clear, 0);
    check_eq("abort_sa_a", sa_a, 0);
    check_eq("abort_sa_b", sa_b, 0);
    check_eq("abort_valid", res_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("abort_no_result", n_vld - vld0, 0);
    check_eq("abort_idle", busy, 0);

    // back-to-back with start held high
    clr0 = n_clr;
    res0 = n_res;
    a_mat = ra; b_mat = bl; start = 1'b1;
    exp_q.push_back(mmul(ra, bl));
    @(negedge clk);
    a_mat = rr; b_mat = ra;
    exp_q.push_back(mmul(rr, ra));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sa_clear && n < 60);
    start = 1'b0;
    n = 0;
    while (n_res < res0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check_eq("b2b_results", n_res - res0, 2);
    check_eq("b2b_clears", n_clr - clr0, 2);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
